// File: rtl/i281_mc_pkg.sv
// rtl/i281_mc_pkg.sv - i281 multicycle opcodes and per-opcode step counts
package i281_mc_pkg;

  localparam logic [3:0] OP_INPUT  = 4'h1;
  localparam logic [3:0] OP_LOAD   = 4'h8;
  localparam logic [3:0] OP_LOADF  = 4'h9;
  localparam logic [3:0] OP_STORE  = 4'hA;
  localparam logic [3:0] OP_STOREF = 4'hB;

  localparam int MAX_STEPS = 4;
  localparam int CNT_W     = 4;

  // INPUT needs a second step that parks until the device has data.
  function automatic logic [CNT_W-1:0] mc_cycles(input logic [3:0] op);
    case (op)
      OP_LOAD, OP_LOADF, OP_STORE, OP_STOREF: mc_cycles = 4'd2;
      OP_INPUT:                               mc_cycles = 4'd2;
      default:                                mc_cycles = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/mc_step_counter.sv
// rtl/mc_step_counter.sv - per-instruction step register with clear/advance/hold
module mc_step_counter #(
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              adv,
  output logic [STEP_W-1:0] step
);

  // clr wins over adv so a finished instruction always restarts at step 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      step <= '0;
    else if (clr)
      step <= '0;
    else if (adv)
      step <= step + 1'b1;
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - sequences IR through execution steps, drives IR/PC loads
module multicycle_sequencer #(
  parameter int STEP_W    = 3,
  parameter int MAX_STEPS = 4,
  parameter int RETIRE_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run_en,
  input  logic [3:0]          opcode,
  input  logic                input_valid,
  output logic                input_req,
  output logic                multicycle_flag,
  output logic                opcode_next_instruction_trigger,
  output logic [STEP_W-1:0]   step,
  output logic                ir_load,
  output logic                pc_load,
  output logic [RETIRE_W-1:0] retired
);
  import i281_mc_pkg::*;

  logic [CNT_W-1:0] raw_total;
  logic [STEP_W:0]  total;
  logic [STEP_W:0]  last_idx;
  logic [STEP_W:0]  step_ext;
  logic             is_input;
  logic             at_last;
  logic             can_adv;
  logic             last;

  always_comb begin
    raw_total = mc_cycles(opcode);
    if (int'(raw_total) > MAX_STEPS)
      total = (STEP_W+1)'(MAX_STEPS);
    else
      total = (STEP_W+1)'(raw_total);
  end

  assign last_idx = total - 1'b1;
  assign step_ext = {1'b0, step};
  assign is_input = (opcode == OP_INPUT);
  // >= rather than == lets an out-of-range step fall back to 0 on the next load.
  assign at_last  = (step_ext >= last_idx);
  assign can_adv  = (step_ext < last_idx);
  assign last     = at_last && (!is_input || input_valid);

  mc_step_counter #(.STEP_W(STEP_W)) u_step (
    .clk   (clk),
    .reset (reset),
    .clr   (run_en & last),
    .adv   (run_en & can_adv),
    .step  (step)
  );

  // Decoded outputs are forced low while reset is held.
  assign multicycle_flag                 = !reset && (total > 1);
  assign opcode_next_instruction_trigger = !reset && run_en && (total > 1) && last;
  assign ir_load                         = !reset && run_en && last;
  assign pc_load                         = !reset && run_en;
  assign input_req                       = !reset && run_en && is_input && (step == STEP_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      retired <= '0;
    else if (ir_load)
      retired <= retired + 1'b1;
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - directed self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_en;
  logic [3:0]  opcode;
  logic        input_valid;
  logic        input_req;
  logic        multicycle_flag;
  logic        trig;
  logic [2:0]  step;
  logic        ir_load;
  logic        pc_load;
  logic [15:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multicycle_sequencer dut (
    .clk                             (clk),
    .reset                           (reset),
    .run_en                          (run_en),
    .opcode                          (opcode),
    .input_valid                     (input_valid),
    .input_req                       (input_req),
    .multicycle_flag                 (multicycle_flag),
    .opcode_next_instruction_trigger (trig),
    .step                            (step),
    .ir_load                         (ir_load),
    .pc_load                         (pc_load),
    .retired                         (retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int exp_step, input int exp_flag,
                            input int exp_trig, input int exp_ir, input int exp_pc,
                            input int exp_req);
    check({tag, ".step"},    32'(step),            exp_step);
    check({tag, ".flag"},    32'(multicycle_flag), exp_flag);
    check({tag, ".trig"},    32'(trig),            exp_trig);
    check({tag, ".ir_load"}, 32'(ir_load),         exp_ir);
    check({tag, ".pc_load"}, 32'(pc_load),         exp_pc);
    check({tag, ".req"},     32'(input_req),       exp_req);
  endtask

  logic [3:0] alu_ops [3];

  initial begin
    alu_ops[0] = 4'h3;
    alu_ops[1] = 4'h4;
    alu_ops[2] = 4'h5;

    reset = 1'b1; run_en = 1'b1; opcode = 4'h8; input_valid = 1'b0;
    tick(); tick();
    check_outs("rst", 0, 0, 0, 0, 0, 0);
    check("rst.retired", 32'(retired), 0);

    // ADD/SUB/ADDI back-to-back: one retire per cycle
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      opcode = alu_ops[i];
      #1;
      check_outs("alu", 0, 0, 0, 1, 1, 0);
      tick();
      check("alu.retired", 32'(retired), i + 1);
    end

    // LOAD: two steps, trigger on the second
    opcode = 4'h8;
    #1;
    check_outs("load0", 0, 1, 0, 0, 1, 0);
    tick();
    check_outs("load1", 1, 1, 1, 1, 1, 0);
    tick();
    check("load.retired", 32'(retired), 4);
    check("load.step", 32'(step), 0);

    // INPUT: valid at step 0 ignored, then wait 3 cycles at step 1
    opcode = 4'h1; input_valid = 1'b1;
    #1;
    check_outs("in0", 0, 1, 0, 0, 1, 0);
    tick();
    input_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_outs("inwait", 1, 1, 0, 0, 1, 1);
      tick();
    end
    input_valid = 1'b1;
    #1;
    check_outs("invalid", 1, 1, 1, 1, 1, 1);
    tick();
    input_valid = 1'b0;
    check("in.step", 32'(step), 0);
    check("in.retired", 32'(retired), 5);

    // STORE with run_en dropped at step 1 for 2 cycles
    opcode = 4'hA;
    #1;
    check_outs("st0", 0, 1, 0, 0, 1, 0);
    tick();
    run_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_outs("stfrz", 1, 1, 0, 0, 0, 0);
      tick();
    end
    check("stfrz.retired", 32'(retired), 5);
    run_en = 1'b1;
    #1;
    check_outs("st1", 1, 1, 1, 1, 1, 0);
    tick();
    check("st.retired", 32'(retired), 6);
    check("st.step", 32'(step), 0);

    // LOADF interrupted by reset at step 1
    opcode = 4'h9;
    tick();
    check("ldf.step1", 32'(step), 1);
    #2;
    reset = 1'b1;
    #1;
    check_outs("ldfrst", 0, 0, 0, 0, 0, 0);
    check("ldfrst.retired", 32'(retired), 0);
    tick();
    reset = 1'b0;
    #1;
    check_outs("ldfr0", 0, 1, 0, 0, 1, 0);
    tick();
    check_outs("ldfr1", 1, 1, 1, 1, 1, 0);
    tick();
    check("ldfr.retired", 32'(retired), 1);

    // retire counter wrap
    opcode = 4'h3;
    repeat (65534) tick();
    check("wrap.max", 32'(retired), 32'hFFFF);
    tick();
    check("wrap.zero", 32'(retired), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
